// File: rtl/uart_replay_buffer_if.sv
// Byte handshake between the replay buffer, the UART receiver and the UART transmitter.
// The buffer takes the slave view; whatever drives rx/tx events takes the master view.
interface uart_replay_buffer_if #(
  parameter int DATA_W = 8
);
  logic              rx_done;
  logic [DATA_W-1:0] rx_data;
  logic              tx_done;
  logic              send_en;
  logic [DATA_W-1:0] tx_data;

  modport master (
    output rx_done,
    output rx_data,
    output tx_done,
    input  send_en,
    input  tx_data
  );

  modport slave (
    input  rx_done,
    input  rx_data,
    input  tx_done,
    output send_en,
    output tx_data
  );
endinterface

// File: rtl/uart_replay_buffer.sv
// Store-and-forward circular byte buffer between the UART receiver and transmitter.
// Drains one byte per transmitter handshake, as a play-triggered burst or as continuous echo.
module uart_replay_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uart_replay_buffer_if.slave  bus,
  input  logic                 play,
  input  logic                 clear,
  input  logic                 auto_mode,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 busy
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    SEND,
    WAIT
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   burst;
  state_t            state;
  logic              auto_q;
  logic              flush_pend;
  logic              send_q;
  logic [DATA_W-1:0] tx_q;
  logic              wr_en;
  logic              pop;

  // clear always wins over a same-cycle write or pop
  assign wr_en = bus.rx_done && !full && !clear;
  assign pop   = (state == READ) && !clear;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);

  // send_q is the registered strobe; a clear landing in SEND withdraws it before the
  // transmitter samples it.
  assign bus.send_en = send_q && !clear;
  assign bus.tx_data = tx_q;

  // NOTE: the storage array has no reset so it maps onto plain RAM; a location is only
  // read after count shows it was written, so undefined power-up contents never escape.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.rx_data;
    end
    if (state == READ) begin
      rd_data <= mem[rd_ptr];
    end
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.rx_done && full) begin
        overflow <= 1'b1;
      end
      if (wr_en && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !wr_en) begin
        count <= count - 1'b1;
      end
    end
  end

  // Drain sequencer: one READ/LOAD/SEND/WAIT pass per transmitted byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      burst      <= '0;
      auto_q     <= 1'b0;
      flush_pend <= 1'b0;
      send_q     <= 1'b0;
      tx_q       <= '0;
    end else begin
      send_q <= 1'b0;
      if (clear) begin
        burst <= '0;
      end

      case (state)
        IDLE: begin
          if (!clear && !empty && (auto_mode || play)) begin
            state  <= READ;
            auto_q <= auto_mode;
            if (!auto_mode) begin
              burst <= count;
            end
          end
        end

        READ: begin
          if (clear) begin
            state <= IDLE;
          end else begin
            if (!auto_q) begin
              burst <= burst - 1'b1;
            end
            state <= LOAD;
          end
        end

        LOAD: begin
          tx_q <= rd_data;
          if (clear) begin
            state <= IDLE;
          end else begin
            state  <= SEND;
            send_q <= 1'b1;
          end
        end

        SEND: begin
          state <= clear ? IDLE : WAIT;
        end

        WAIT: begin
          // A byte is already on the wire; a flush must still wait for its tx_done.
          if (clear) begin
            flush_pend <= 1'b1;
          end
          if (bus.tx_done) begin
            flush_pend <= 1'b0;
            if (!clear && !flush_pend && !empty && (auto_q || (burst != '0))) begin
              state <= READ;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_replay_buffer.md
# uart_replay_buffer

Parametrised store-and-forward buffer between `uart_byte_rx` and `uart_byte_tx`, replacing the fixed 256×8 RAM plus its address controller. Received bytes are written into an internal circular FIFO with full/empty/count tracking and sticky overflow. Bytes are drained to the transmitter one at a time, either as a burst on a play pulse (from `key_filter`) or continuously in auto-echo mode. A clear command flushes the buffer.

## Interface
- `DATA_W`, default 8: byte width. Must match the rx/tx data width.
- `ADDR_W`, default 8: pointer width. Depth is `DEPTH = 2**ADDR_W`.
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `rx_done`  in  1  one-cycle pulse: `rx_data` is valid.
- `rx_data`  in  DATA_W  received byte.
- `tx_done`  in  1  one-cycle pulse from the transmitter: the byte has finished.
- `play`  in  1  one-cycle pulse: start a burst of all currently stored bytes (manual mode only).
- `clear`  in  1  one-cycle pulse: flush the buffer and clear `overflow`.
- `auto_mode`  in  1  1 = drain whenever non-empty; 0 = drain only on `play`. Sampled only in IDLE.
- `send_en`  out  1  one-cycle pulse to the transmitter.
- `tx_data`  out  DATA_W  byte to transmit. Registered.
- `count`  out  ADDR_W+1  number of stored bytes, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a write was dropped because the buffer was full.
- `busy`  out  1  FSM not in IDLE.

## Operation
- **Storage:** DEPTH×DATA_W memory with synchronous write and synchronous read (1-cycle read latency). `wr_ptr`, `rd_ptr` are ADDR_W bits wide and wrap modulo DEPTH.
- **Write:**
  - `rx_done` while not full: `mem[wr_ptr] <= rx_data`, `wr_ptr++`.
  - `rx_done` while full: byte dropped, `overflow <= 1`, pointers unchanged.
- **Pop:** occurs in state READ: `rd_ptr++`.
- **Count:** +1 on write, -1 on pop. A simultaneous write and pop leave `count` unchanged.
- **FSM states:**
  - IDLE → READ when (`auto_mode` & !empty) or (!`auto_mode` & `play` & !empty). On a `play` start, `burst <= count`.
  - READ: memory address = `rd_ptr`; pop; in manual mode `burst--`. → LOAD.
  - LOAD: `tx_data <= mem data`. → SEND.
  - SEND: `send_en = 1` for this cycle only. → WAIT.
  - WAIT: on `tx_done`, → READ if (manual & `burst != 0` & !empty) or (auto & !empty); otherwise → IDLE.
- **Ignored inputs:**
  - `play` outside IDLE, or with the buffer empty, is ignored.
  - `tx_done` outside WAIT is ignored.
- **Bytes arriving during a burst:** stored, but not part of the current burst (`burst` is latched at start).
- **Clear (any state):**
  - Effects: `wr_ptr`, `rd_ptr`, `count`, `burst`, `overflow` <= 0.
  - In READ or LOAD → IDLE, and no `send_en` is issued.
  - In SEND, `send_en` is suppressed → IDLE.
  - In WAIT, remain in WAIT until `tx_done`, then → IDLE.
  - `clear` together with `rx_done`: clear wins and the byte is dropped.
  - `clear` together with `play`: clear wins and `play` is ignored.
- **No read-during-write hazard:** `count` becomes nonzero only after the write has committed.

## Timing
- **Reset values:** `send_en=0`, `tx_data=0`, `count=0`, `full=0`, `empty=1`, `overflow=0`, `busy=0`. FSM = IDLE, pointers = 0, `burst=0`, memory contents undefined.
- **Reset mid-operation:** asynchronous return to reset values; any in-progress burst is abandoned.
- **Manual mode:** `play` sampled at edge N → READ in cycle N+1, LOAD in N+2, SEND in N+3 (`send_en` high). WAIT from N+4.
- **Auto mode:** `rx_done` at edge N with the buffer empty → `count=1` in N+1, READ in N+2, `send_en` in N+4.
- **Back-to-back bytes:** `tx_done` at edge M → next `send_en` at cycle M+3.
- `tx_data` stays stable from `send_en` until the next LOAD.
- **Flags:** `count`, `full` and `empty` update one cycle after the causing edge (registered). `overflow` is set the cycle after the dropped write.

## Test plan
- **Burst in order:** `ADDR_W=2`, manual mode. Write 0x11, 0x22, 0x33, then pulse `play`. Required: exactly 3 `send_en` pulses with `tx_data` 0x11, 0x22, 0x33 in order, each `send_en` 3 cycles after `tx_done`. Ends with `empty=1`, `busy=0`.
- **Full and overflow:** `ADDR_W=2`. Write 0xA0–0xA4. Required: `full=1`, `count=4`, `overflow=1`. `play` sends 0xA0–0xA3 only. A later `clear` → `overflow=0`.
- **Wrap-around:** `ADDR_W=2`. Write 3, drain 3, then write 4 (0xC0–0xC3). Required: pointers wrap, `full=1`, and `play` sends 0xC0–0xC3 in order.
- **Auto echo with mid-stream writes:** `auto_mode=1`. Write 0x55 → `send_en` 3 cycles after `count=1`. Writing 0x66 during WAIT → sent immediately after the 0x55 `tx_done`. The FSM never drains a byte that was not stored.
- **Clear and simultaneous events:**
  - `clear` in LOAD → no `send_en` issued, `count=0`, FSM in IDLE.
  - `clear` in WAIT → FSM stays in WAIT until `tx_done`, then IDLE.
  - `rx_done` and READ pop in the same cycle at `count=2` → `count` stays 2.
- **Async reset mid-burst:** assert `reset_n=0` during WAIT of the 2nd of 3 bytes. Required: all outputs take reset values immediately, and no further `send_en` after release.
